// File: rtl/io_stream_bridge_pkg.sv
// Shared constants and types for the memory-mapped I/O stream bridge.
package io_pkg;

   localparam logic [31:0] IO_ADDR   = 32'hFFFF_FFFF;
   localparam int          IO_DATA_W = 32;
   localparam int          IO_DEPTH  = 4;
   localparam int          IO_CNT_W  = $clog2(IO_DEPTH) + 1;

   typedef struct packed {
      logic                full;
      logic                empty;
      logic [IO_CNT_W-1:0] count;
   } io_fifo_status_t;

endpackage

// File: rtl/io_stream_bridge_if.sv
// Core-side I/O strobes plus the TX/RX valid/ready streams of the bridge.
interface io_stream_bridge_if #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
) ();

   localparam int LVL_W = $clog2(DEPTH) + 1;

   logic              io_write_en;
   logic [DATA_W-1:0] io_data_out;
   logic              io_read_en;
   logic [DATA_W-1:0] io_rdata;
   logic              io_busy;
   logic [DATA_W-1:0] tx_data;
   logic              tx_valid;
   logic              tx_ready;
   logic [DATA_W-1:0] rx_data;
   logic              rx_valid;
   logic              rx_ready;
   logic [LVL_W-1:0]  tx_level;
   logic [LVL_W-1:0]  rx_level;

   modport slave (
      input  io_write_en, io_data_out, io_read_en, tx_ready, rx_data, rx_valid,
      output io_rdata, io_busy, tx_data, tx_valid, rx_ready, tx_level, rx_level
   );

   modport master (
      output io_write_en, io_data_out, io_read_en, tx_ready, rx_data, rx_valid,
      input  io_rdata, io_busy, tx_data, tx_valid, rx_ready, tx_level, rx_level
   );

endinterface

// File: rtl/io_sync_fifo.sv
// Synchronous show-ahead FIFO; head reads as zero while empty.
module io_sync_fifo
   import io_pkg::*;
#(
   parameter int DATA_W = IO_DATA_W,
   parameter int DEPTH  = IO_DEPTH
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            push,
   input  logic [DATA_W-1:0] wr_data,
   input  logic            pop,
   output logic [DATA_W-1:0] rd_data,
   output io_fifo_status_t status
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              full, empty, do_push, do_pop;

   always_comb begin
      full     = (count_q == CW'(DEPTH));
      empty    = (count_q == '0);
      do_push  = push && !full;
      do_pop   = pop && !empty;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = wr_data;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      rd_data      = empty ? '0 : mem_q[rd_ptr_q];
      status.full  = full;
      status.empty = empty;
      status.count = IO_CNT_W'(count_q);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/io_stream_bridge.sv
// I/O endpoint: core writes drain to the TX stream, the RX stream feeds core reads.
module io_stream_bridge
   import io_pkg::*;
#(
   parameter int DATA_W = IO_DATA_W,
   parameter int DEPTH  = IO_DEPTH
) (
   input logic              clk,
   input logic              reset_n,
   io_stream_bridge_if.slave bus
);

   localparam int LVL_W = $clog2(DEPTH) + 1;

   io_fifo_status_t   tx_st, rx_st;
   logic [DATA_W-1:0] tx_head, rx_head;
   logic              tx_push, tx_pop, rx_push, rx_pop;

   // A full TX refuses the write even if it drains this cycle; io_busy makes the core retry.
   always_comb begin
      tx_push = bus.io_write_en && !tx_st.full;
      tx_pop  = !tx_st.empty && bus.tx_ready;
      rx_push = bus.rx_valid && !rx_st.full;
      rx_pop  = bus.io_read_en && !rx_st.empty;
   end

   io_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_tx_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (tx_push),
      .wr_data (bus.io_data_out),
      .pop     (tx_pop),
      .rd_data (tx_head),
      .status  (tx_st)
   );

   io_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_rx_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (rx_push),
      .wr_data (bus.rx_data),
      .pop     (rx_pop),
      .rd_data (rx_head),
      .status  (rx_st)
   );

   assign bus.tx_valid = !tx_st.empty;
   assign bus.tx_data  = tx_head;
   assign bus.rx_ready = !rx_st.full;
   assign bus.io_rdata = rx_head;
   assign bus.io_busy  = (bus.io_write_en && tx_st.full) || (bus.io_read_en && rx_st.empty);
   assign bus.tx_level = LVL_W'(tx_st.count);
   assign bus.rx_level = LVL_W'(rx_st.count);

endmodule

// File: tb/tb_io_stream_bridge.sv
// Queue-based reference model with per-cycle compare, plus directed scenarios with literal expectations.
module tb_io_stream_bridge;

   localparam int DW = 32;
   localparam int DP = 4;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   io_stream_bridge_if #(.DATA_W(DW), .DEPTH(DP)) bus ();

   io_stream_bridge #(.DATA_W(DW), .DEPTH(DP)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int checks = 0;
   int errors = 0;
   int max_tx_level = 0;
   logic [DW-1:0] txq[$];
   logic [DW-1:0] rxq[$];
   logic [DW-1:0] tx_out[$];

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Reference model: FIFOs as queues, updated from the inputs seen at each rising edge.
   bit m_tpush, m_tpop, m_rpush, m_rpop;
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         txq.delete();
         rxq.delete();
      end else begin
         m_tpush = bus.io_write_en && (txq.size() < DP);
         m_tpop  = (txq.size() > 0) && bus.tx_ready;
         m_rpush = bus.rx_valid && (rxq.size() < DP);
         m_rpop  = bus.io_read_en && (rxq.size() > 0);
         if (m_tpop)  void'(txq.pop_front());
         if (m_tpush) txq.push_back(bus.io_data_out);
         if (m_rpop)  void'(rxq.pop_front());
         if (m_rpush) rxq.push_back(bus.rx_data);
      end
   end

   always @(negedge clk) begin
      chk("tx_valid", 32'(bus.tx_valid), 32'(txq.size() > 0));
      chk("tx_data",  bus.tx_data, (txq.size() > 0) ? txq[0] : '0);
      chk("rx_ready", 32'(bus.rx_ready), 32'(rxq.size() < DP));
      chk("io_rdata", bus.io_rdata, (rxq.size() > 0) ? rxq[0] : '0);
      chk("io_busy",  32'(bus.io_busy),
          32'((bus.io_write_en && txq.size() == DP) || (bus.io_read_en && rxq.size() == 0)));
      chk("tx_level", 32'(bus.tx_level), 32'(txq.size()));
      chk("rx_level", 32'(bus.rx_level), 32'(rxq.size()));
      if (bus.tx_valid && bus.tx_ready) tx_out.push_back(bus.tx_data);
      if (int'(bus.tx_level) > max_tx_level) max_tx_level = int'(bus.tx_level);
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1);
   end

   logic [DW-1:0] exp_list[$];
   logic acc;
   int   nxt, k, budget;

   initial begin
      bus.io_write_en = 1'b0;
      bus.io_data_out = '0;
      bus.io_read_en  = 1'b0;
      bus.tx_ready    = 1'b0;
      bus.rx_data     = '0;
      bus.rx_valid    = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
      chk("rst_rx_ready", 32'(bus.rx_ready), 32'd1);
      chk("rst_io_busy",  32'(bus.io_busy),  32'd0);
      chk("rst_io_rdata", bus.io_rdata, 32'd0);
      chk("rst_tx_data",  bus.tx_data,  32'd0);
      chk("rst_tx_level", 32'(bus.tx_level), 32'd0);
      chk("rst_rx_level", 32'(bus.rx_level), 32'd0);
      reset_n = 1'b1;
      cyc();

      // Three writes streaming straight through
      bus.tx_ready = 1'b1;
      tx_out.delete();
      max_tx_level = 0;
      exp_list = '{32'hA1, 32'hA2, 32'hA3};
      for (int i = 0; i < 3; i++) begin
         bus.io_write_en = 1'b1;
         bus.io_data_out = exp_list[i];
         #1;
         chk("t1_busy", 32'(bus.io_busy), 32'd0);
         cyc();
         chk("t1_valid", 32'(bus.tx_valid), 32'd1);
         chk("t1_data",  bus.tx_data, exp_list[i]);
      end
      bus.io_write_en = 1'b0;
      cyc();
      chk("t1_count", 32'(tx_out.size()), 32'd3);
      for (int i = 0; i < 3; i++)
         chk("t1_order", (i < tx_out.size()) ? tx_out[i] : 'x, exp_list[i]);
      chk("t1_max_level", 32'(max_tx_level), 32'd1);

      // Fill TX, block the fifth write, free one slot
      bus.tx_ready = 1'b0;
      tx_out.delete();
      for (int i = 0; i < 4; i++) begin
         bus.io_write_en = 1'b1;
         bus.io_data_out = 32'h10 + i;
         cyc();
      end
      bus.io_data_out = 32'h14;
      #1;
      chk("t2_busy_full", 32'(bus.io_busy), 32'd1);
      chk("t2_level4",    32'(bus.tx_level), 32'd4);
      bus.tx_ready = 1'b1;
      cyc();
      bus.tx_ready = 1'b0;
      #1;
      chk("t2_level3",    32'(bus.tx_level), 32'd3);
      chk("t2_busy_drop", 32'(bus.io_busy), 32'd0);
      cyc();
      bus.io_write_en = 1'b0;
      #1;
      chk("t2_level_back4", 32'(bus.tx_level), 32'd4);
      bus.tx_ready = 1'b1;
      repeat (4) cyc();
      bus.tx_ready = 1'b0;
      #1;
      chk("t2_level0", 32'(bus.tx_level), 32'd0);
      exp_list = '{32'h10, 32'h11, 32'h12, 32'h13, 32'h14};
      chk("t2_count", 32'(tx_out.size()), 32'd5);
      for (int i = 0; i < 5; i++)
         chk("t2_order", (i < tx_out.size()) ? tx_out[i] : 'x, exp_list[i]);

      // Read from empty RX, then a single word arrives
      bus.io_read_en = 1'b1;
      #1;
      chk("t3_busy_empty",  32'(bus.io_busy), 32'd1);
      chk("t3_rdata_empty", bus.io_rdata, 32'd0);
      bus.rx_valid = 1'b1;
      bus.rx_data  = 32'hDEAD_BEEF;
      cyc();
      bus.rx_valid = 1'b0;
      #1;
      chk("t3_rdata", bus.io_rdata, 32'hDEAD_BEEF);
      chk("t3_busy",  32'(bus.io_busy), 32'd0);
      cyc();
      bus.io_read_en = 1'b0;
      #1;
      chk("t3_rx_level", 32'(bus.rx_level), 32'd0);
      chk("t3_rdata_after", bus.io_rdata, 32'd0);

      // RX fills to DEPTH and applies backpressure
      nxt = 1;
      for (int i = 0; i < 6; i++) begin
         bus.rx_valid = 1'b1;
         bus.rx_data  = DW'(nxt);
         #1;
         acc = bus.rx_ready;
         cyc();
         if (acc) nxt++;
      end
      bus.rx_valid = 1'b0;
      #1;
      chk("t4_accepted", DW'(nxt - 1), 32'd4);
      chk("t4_rx_level", 32'(bus.rx_level), 32'd4);
      chk("t4_rx_ready", 32'(bus.rx_ready), 32'd0);
      for (int i = 0; i < 4; i++) begin
         bus.io_read_en = 1'b1;
         #1;
         chk("t4_rdata", bus.io_rdata, DW'(i + 1));
         cyc();
      end
      bus.io_read_en = 1'b0;
      #1;
      chk("t4_rx_ready_back", 32'(bus.rx_ready), 32'd1);
      chk("t4_rx_level0", 32'(bus.rx_level), 32'd0);

      // Pointer wrap with toggling tx_ready and write retries
      tx_out.delete();
      bus.tx_ready = 1'b0;
      k = 0;
      budget = 0;
      while (k < 10 && budget < 100) begin
         bus.tx_ready    = ~bus.tx_ready;
         bus.io_write_en = 1'b1;
         bus.io_data_out = 32'h100 + DW'(k);
         #1;
         acc = !bus.io_busy;
         cyc();
         if (acc) k++;
         budget++;
      end
      bus.io_write_en = 1'b0;
      chk("t5_all_written", DW'(k), 32'd10);
      budget = 0;
      while (bus.tx_level != '0 && budget < 40) begin
         bus.tx_ready = ~bus.tx_ready;
         cyc();
         budget++;
      end
      bus.tx_ready = 1'b0;
      #1;
      chk("t5_level0", 32'(bus.tx_level), 32'd0);
      chk("t5_count", 32'(tx_out.size()), 32'd10);
      for (int i = 0; i < 10; i++)
         chk("t5_order", (i < tx_out.size()) ? tx_out[i] : 'x, 32'h100 + DW'(i));

      // Reset while TX holds data
      tx_out.delete();
      bus.io_write_en = 1'b1;
      bus.io_data_out = 32'h77;
      cyc();
      bus.io_data_out = 32'h78;
      cyc();
      bus.io_write_en = 1'b0;
      #1;
      chk("t6_level2", 32'(bus.tx_level), 32'd2);
      chk("t6_valid_pre", 32'(bus.tx_valid), 32'd1);
      reset_n = 1'b0;
      #1;
      chk("t6_valid_rst", 32'(bus.tx_valid), 32'd0);
      chk("t6_tx_level",  32'(bus.tx_level), 32'd0);
      chk("t6_rx_level",  32'(bus.rx_level), 32'd0);
      chk("t6_tx_data",   bus.tx_data, 32'd0);
      cyc();
      cyc();
      reset_n = 1'b1;
      bus.io_write_en = 1'b1;
      bus.io_data_out = 32'h55;
      cyc();
      bus.io_write_en = 1'b0;
      #1;
      chk("t6_valid_new", 32'(bus.tx_valid), 32'd1);
      chk("t6_data_new",  bus.tx_data, 32'h55);
      bus.tx_ready = 1'b1;
      cyc();
      bus.tx_ready = 1'b0;
      #1;
      chk("t6_count", 32'(tx_out.size()), 32'd1);
      chk("t6_first", (tx_out.size() > 0) ? tx_out[0] : 'x, 32'h55);

      cyc();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/io_stream_bridge.md
Name: io_stream_bridge

Overview:
- Memory-mapped I/O endpoint sitting directly downstream of the RAM controller's I/O port (address 0xFFFF_FFFF).
- Buffers core writes into a TX FIFO that drains to an external valid/ready stream.
- Buffers an external RX valid/ready stream into an RX FIFO whose head is returned on core reads.
- Generates io_busy so the controller stalls the core whenever a write cannot be accepted or a read has no data.

Parameters:
DATA_W, 32, width of I/O data words
DEPTH, 4, entries per FIFO; power of 2, minimum 2

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
io_write_en  in  1  write strobe from RAM controller (I/O write)
io_data_out  in  DATA_W  write data from RAM controller
io_read_en  in  1  read strobe from RAM controller (I/O read)
io_rdata  out  DATA_W  read data to RAM controller
io_busy  out  1  stall request to RAM controller
tx_data  out  DATA_W  outbound stream data
tx_valid  out  1  outbound stream valid
tx_ready  in  1  outbound stream ready
rx_data  in  DATA_W  inbound stream data
rx_valid  in  1  inbound stream valid
rx_ready  out  1  inbound stream ready
tx_level  out  $clog2(DEPTH)+1  TX FIFO occupancy, debug/status
rx_level  out  $clog2(DEPTH)+1  RX FIFO occupancy, debug/status

Behaviour:
- Reset (async assert, sync release): both FIFOs empty, pointers 0; tx_valid=0, rx_ready=1, io_busy=0, io_rdata=0, tx_data=0, levels=0.
- FIFO structure:
  - Each FIFO is synchronous, show-ahead (head visible combinationally when non-empty).
  - Read/write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - Count is $clog2(DEPTH)+1 bits; full is count==DEPTH, empty is count==0.
- TX push:
  - Occurs when io_write_en=1 and TX not full; io_data_out is written on that clock edge.
  - When TX is full, the push is blocked even if a pop happens in the same cycle (no full-bypass). io_busy holds until a slot is free, so the controller retries.
- TX pop:
  - tx_valid = !tx_empty; tx_data = TX head.
  - Pop occurs on tx_valid && tx_ready.
  - tx_data must stay stable while tx_valid=1 and tx_ready=0.
- RX push:
  - rx_ready = !rx_full; push on rx_valid && rx_ready.
  - No overrun is possible.
- RX pop:
  - io_rdata = RX head when non-empty, otherwise 0.
  - Pop on io_read_en && !rx_empty, one entry per cycle that io_read_en is high.
  - The controller leaves its read state in the cycle io_busy drops, so it consumes exactly one word.
- io_busy (combinational): (io_write_en && tx_full) || (io_read_en && rx_empty).
  - Both strobes high at once is illegal; on a simultaneous strobe the block asserts io_busy if either condition holds and performs each permitted operation independently.
- Simultaneous push and pop on the same FIFO (not full, not empty): count unchanged, both pointers advance.
- Empty FIFO with a push: the new word becomes visible at the head the cycle after the push (latency 1); no same-cycle bypass.
- Write-to-stream latency: io_write_en into an empty TX gives tx_valid=1 on the next cycle.
- Reset mid-operation: all buffered data is discarded, and tx_valid drops immediately on reset assertion.

Decomposition:
- Shared package io_pkg holds:
  - IO_ADDR = 32'hFFFF_FFFF
  - default DATA_W and DEPTH constants
  - an io_fifo_status_t struct {full, empty, count}
- One sub-module io_sync_fifo (parameterised DATA_W, DEPTH; push/pop/data/status) is instantiated twice, once for TX and once for RX.
- The top level contains only the handshake and busy logic.

Test Plan:
- Reset, then 3 writes 0xA1, 0xA2, 0xA3 with tx_ready=1 -> tx_data sequence A1, A2, A3, each tx_valid one cycle after its write; io_busy=0 throughout; tx_level never exceeds 1.
- tx_ready=0, 5 writes 0x10..0x14 with DEPTH=4 -> io_busy=1 on the 5th write, tx_level=4; raise tx_ready for one cycle -> 0x10 drains, 0x14 is accepted the next cycle, io_busy drops.
- Empty RX, io_read_en=1 -> io_busy=1, io_rdata=0; rx_valid pulse with 0xDEAD_BEEF -> next cycle io_rdata=0xDEADBEEF, io_busy=0, entry popped, rx_level=0.
- rx_valid held with 0x1..0x6, no reads -> rx_ready=0 after 4 accepts, rx_level=4; read 4 times -> io_rdata 1, 2, 3, 4 in order; rx_ready returns high.
- Pointer wrap: 10 write/drain cycles with tx_ready toggling every cycle -> every word out in order, no loss or duplication, tx_level returns to 0.
- Reset asserted with 2 words in TX and tx_ready=0 -> tx_valid=0 immediately, levels=0; after release, a new write 0x55 appears as the first tx_data.
